// File: rtl/gyro_rd_seq.sv
// gyro_rd_seq: power-up / read command sequencer feeding the SPI monarch.
// Waits for the gyro to settle, writes three configuration registers, then
// answers every data-ready interrupt with a low/high yaw-rate byte read and
// hands the assembled signed yaw rate to the heading integrator.
module gyro_rd_seq #(
   parameter int          STARTUP_W = 16,
   parameter logic [15:0] CMD_INIT1 = 16'h0D02,
   parameter logic [15:0] CMD_INIT2 = 16'h1160,
   parameter logic [15:0] CMD_INIT3 = 16'h1440,
   parameter logic [15:0] CMD_RDL   = 16'hA600,
   parameter logic [15:0] CMD_RDH   = 16'hA700
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INT,
   output logic        wrt,
   output logic [15:0] cmd,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        init_done,
   output logic [15:0] yaw_rt,
   output logic        vld
);

   // Every state except SETTLE and WAIT_INT is the wait phase of a transaction;
   // its issue cycle is the edge that enters the state.
   typedef enum logic [2:0] {
      ST_SETTLE,
      ST_INIT1,
      ST_INIT2,
      ST_INIT3,
      ST_WAIT_INT,
      ST_RDL,
      ST_RDH
   } state_t;

   state_t               r_state;
   logic [STARTUP_W-1:0] r_settleCnt;
   logic                 r_intMeta;
   logic                 r_intSync;
   logic                 r_doneQ;
   logic                 r_doneRise;
   logic [7:0]           r_rdByte;
   logic [7:0]           r_lowByte;
   logic                 w_doneAccept;
   logic                 w_unusedRdHi;

   // Only the low byte of each SPI reply carries yaw data.
   assign w_unusedRdHi = ^rd_data[15:8];

   // A done rise seen while wrt is still high predates the monarch seeing the
   // new command, so it belongs to the previous transaction and is dropped.
   assign w_doneAccept = r_doneRise & ~wrt;

   // Two-flop synchronizer for the asynchronous data-ready interrupt.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_intMeta <= 1'b0;
         r_intSync <= 1'b0;
      end else begin
         r_intMeta <= INT;
         r_intSync <= r_intMeta;
      end
   end

   // Registered rising-edge detect on done, capturing the reply byte with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_doneQ    <= 1'b0;
         r_doneRise <= 1'b0;
         r_rdByte   <= 8'h00;
      end else begin
         r_doneQ    <= done;
         r_doneRise <= done & ~r_doneQ;
         if (done & ~r_doneQ) begin
            r_rdByte <= rd_data[7:0];
         end
      end
   end

   // Sequencer: settle, configure, then service interrupts with byte-pair reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_SETTLE;
         r_settleCnt <= '0;
         r_lowByte   <= 8'h00;
         wrt         <= 1'b0;
         cmd         <= 16'h0000;
         init_done   <= 1'b0;
         yaw_rt      <= 16'h0000;
         vld         <= 1'b0;
      end else begin
         wrt <= 1'b0;
         vld <= 1'b0;
         case (r_state)
            ST_SETTLE: begin
               if (r_settleCnt == '1) begin
                  wrt     <= 1'b1;
                  cmd     <= CMD_INIT1;
                  r_state <= ST_INIT1;
               end else begin
                  r_settleCnt <= r_settleCnt + STARTUP_W'(1);
               end
            end
            ST_INIT1: begin
               if (w_doneAccept) begin
                  wrt     <= 1'b1;
                  cmd     <= CMD_INIT2;
                  r_state <= ST_INIT2;
               end
            end
            ST_INIT2: begin
               if (w_doneAccept) begin
                  wrt     <= 1'b1;
                  cmd     <= CMD_INIT3;
                  r_state <= ST_INIT3;
               end
            end
            ST_INIT3: begin
               if (w_doneAccept) begin
                  init_done <= 1'b1;
                  r_state   <= ST_WAIT_INT;
               end
            end
            ST_WAIT_INT: begin
               if (r_intSync) begin
                  wrt     <= 1'b1;
                  cmd     <= CMD_RDL;
                  r_state <= ST_RDL;
               end
            end
            ST_RDL: begin
               if (w_doneAccept) begin
                  r_lowByte <= r_rdByte;
                  wrt       <= 1'b1;
                  cmd       <= CMD_RDH;
                  r_state   <= ST_RDH;
               end
            end
            ST_RDH: begin
               if (w_doneAccept) begin
                  yaw_rt  <= {r_rdByte, r_lowByte};
                  vld     <= 1'b1;
                  r_state <= ST_WAIT_INT;
               end
            end
            default: begin
               r_state <= ST_SETTLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gyro_rd_seq.sv
// tb_gyro_rd_seq: self-checking bench for gyro_rd_seq with a short settle time.
module tb_gyro_rd_seq;

   localparam int STARTUP_W   = 4;
   localparam int SETTLE_CLKS = 1 << STARTUP_W;

   logic        clk;
   logic        rst;
   logic        INT;
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] rd_data;
   logic        init_done;
   logic [15:0] yaw_rt;
   logic        vld;

   int          nChecks = 0;
   int          nFail   = 0;
   logic [15:0] lastYaw = 16'h0000;

   gyro_rd_seq #(.STARTUP_W(STARTUP_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .INT       (INT),
      .wrt       (wrt),
      .cmd       (cmd),
      .done      (done),
      .rd_data   (rd_data),
      .init_done (init_done),
      .yaw_rt    (yaw_rt),
      .vld       (vld)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Yaw rate the integrator should see: high reply byte over low reply byte.
   function automatic logic [15:0] expYaw(input logic [15:0] lo, input logic [15:0] hi);
      int v;
      v = (int'(hi) % 256) * 256 + (int'(lo) % 256);
      return 16'(v);
   endfunction

   // SPI monarch stand-in: wait for wrt, drop done, hold for lat clocks, then reply.
   task automatic spiTxn(input int maxWait, input int lat, input logic [15:0] rdVal,
                         output bit gotWrt, output int delay, output logic [15:0] cmdSeen,
                         output logic wrtNext, output bit cmdStable);
      gotWrt = 0; delay = 0; cmdSeen = '0; wrtNext = 1'b0; cmdStable = 1;
      while (!gotWrt && delay < maxWait) begin
         @(negedge clk);
         delay++;
         if (wrt === 1'b1) gotWrt = 1;
      end
      if (gotWrt) begin
         cmdSeen = cmd;
         done = 1'b0;
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (i == 0) wrtNext = wrt;
            if (cmd !== cmdSeen) cmdStable = 0;
         end
         rd_data = rdVal;
         done = 1'b1;
      end
   endtask

   // Wait (bounded) for a vld pulse and grab yaw_rt with it.
   task automatic waitVld(input int maxWait, output bit got, output int n, output logic [15:0] y);
      got = 0; n = 0; y = '0;
      while (!got && n < maxWait) begin
         @(negedge clk);
         n++;
         if (vld === 1'b1) begin got = 1; y = yaw_rt; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; INT = 1'b0; done = 1'b0; rd_data = 16'h0000;
      repeat (3) @(negedge clk);
      nChecks++; if (wrt !== 1'b0) begin nFail++; $display("[TB] FAIL reset_wrt: got %b expected 0", wrt); end
      nChecks++; if (cmd !== 16'h0000) begin nFail++; $display("[TB] FAIL reset_cmd: got %h expected 0000", cmd); end
      nChecks++; if (init_done !== 1'b0) begin nFail++; $display("[TB] FAIL reset_init_done: got %b expected 0", init_done); end
      nChecks++; if (yaw_rt !== 16'h0000) begin nFail++; $display("[TB] FAIL reset_yaw: got %h expected 0000", yaw_rt); end
      nChecks++; if (vld !== 1'b0) begin nFail++; $display("[TB] FAIL reset_vld: got %b expected 0", vld); end
      lastYaw = 16'h0000;
   endtask

   task automatic test_startup;
      bit got; int dly; logic [15:0] c; logic wn; bit st;
      rst = 1'b0;
      spiTxn(100, 40, 16'($urandom), got, dly, c, wn, st);
      nChecks++; if (got !== 1'b1) begin nFail++; $display("[TB] FAIL startup_wrt_seen: got %0b expected 1", got); end
      nChecks++; if (dly != SETTLE_CLKS) begin nFail++; $display("[TB] FAIL startup_delay: got %0d expected %0d", dly, SETTLE_CLKS); end
      nChecks++; if (c !== 16'h0D02) begin nFail++; $display("[TB] FAIL startup_cmd: got %h expected 0d02", c); end
      nChecks++; if (wn !== 1'b0) begin nFail++; $display("[TB] FAIL startup_wrt_width: got %b expected 0", wn); end
      nChecks++; if (st !== 1'b1) begin nFail++; $display("[TB] FAIL startup_cmd_stable: got %0b expected 1", st); end
      nChecks++; if (init_done !== 1'b0) begin nFail++; $display("[TB] FAIL startup_init_done: got %b expected 0", init_done); end
   endtask

   task automatic test_init;
      bit got; int dly; logic [15:0] c; logic wn; bit st; int nWrt;
      logic [15:0] expCmd [2];
      expCmd[0] = 16'h1160; expCmd[1] = 16'h1440;
      for (int i = 0; i < 2; i++) begin
         spiTxn(10, 40, 16'($urandom), got, dly, c, wn, st);
         nChecks++; if (got !== 1'b1 || dly != 2) begin nFail++; $display("[TB] FAIL init%0d_latency: got seen=%0b dly=%0d expected seen=1 dly=2", i + 2, got, dly); end
         nChecks++; if (c !== expCmd[i]) begin nFail++; $display("[TB] FAIL init%0d_cmd: got %h expected %h", i + 2, c, expCmd[i]); end
         nChecks++; if (wn !== 1'b0 || st !== 1'b1) begin nFail++; $display("[TB] FAIL init%0d_wrt_cmd: got wrtNext=%b stable=%0b expected 0/1", i + 2, wn, st); end
         nChecks++; if (init_done !== 1'b0) begin nFail++; $display("[TB] FAIL init%0d_early_done: got %b expected 0", i + 2, init_done); end
      end
      @(negedge clk);
      nChecks++; if (init_done !== 1'b0) begin nFail++; $display("[TB] FAIL init_done_plus1: got %b expected 0", init_done); end
      @(negedge clk);
      nChecks++; if (init_done !== 1'b1) begin nFail++; $display("[TB] FAIL init_done_plus2: got %b expected 1", init_done); end
      nWrt = 0;
      repeat (20) begin @(negedge clk); if (wrt === 1'b1) nWrt++; end
      nChecks++; if (nWrt != 0) begin nFail++; $display("[TB] FAIL init_idle_wrt: got %0d pulses expected 0", nWrt); end
      nChecks++; if (init_done !== 1'b1) begin nFail++; $display("[TB] FAIL init_done_sticky: got %b expected 1", init_done); end
   endtask

   task automatic test_single_read;
      bit got; int dly; logic [15:0] c; logic wn; bit st; int n; logic [15:0] y; int nWrt;
      logic [15:0] lo, hi, e;
      lo = 16'h00CD; hi = 16'h00AB; e = expYaw(lo, hi);
      INT = 1'b1;
      spiTxn(10, $urandom_range(3, 20), lo, got, dly, c, wn, st);
      nChecks++; if (got !== 1'b1 || dly != 3) begin nFail++; $display("[TB] FAIL rd_int_latency: got seen=%0b dly=%0d expected seen=1 dly=3", got, dly); end
      nChecks++; if (c !== 16'hA600 || wn !== 1'b0) begin nFail++; $display("[TB] FAIL rd_rdl_cmd: got %h wrtNext=%b expected a600/0", c, wn); end
      INT = 1'b0;
      spiTxn(10, $urandom_range(3, 20), hi, got, dly, c, wn, st);
      nChecks++; if (got !== 1'b1 || dly != 2) begin nFail++; $display("[TB] FAIL rd_rdh_latency: got seen=%0b dly=%0d expected seen=1 dly=2", got, dly); end
      nChecks++; if (c !== 16'hA700 || st !== 1'b1) begin nFail++; $display("[TB] FAIL rd_rdh_cmd: got %h stable=%0b expected a700/1", c, st); end
      nChecks++; if (yaw_rt !== lastYaw || vld !== 1'b0) begin nFail++; $display("[TB] FAIL rd_yaw_early: got %h vld=%b expected %h vld=0", yaw_rt, vld, lastYaw); end
      waitVld(10, got, n, y);
      nChecks++; if (got !== 1'b1 || n != 2) begin nFail++; $display("[TB] FAIL rd_vld_latency: got seen=%0b n=%0d expected seen=1 n=2", got, n); end
      nChecks++; if (y !== e) begin nFail++; $display("[TB] FAIL rd_yaw_value: got %h expected %h", y, e); end
      lastYaw = e;
      @(negedge clk);
      nChecks++; if (vld !== 1'b0 || yaw_rt !== lastYaw) begin nFail++; $display("[TB] FAIL rd_vld_width: got vld=%b yaw=%h expected 0/%h", vld, yaw_rt, lastYaw); end
      nWrt = 0;
      repeat (15) begin @(negedge clk); if (wrt === 1'b1) nWrt++; end
      nChecks++; if (nWrt != 0) begin nFail++; $display("[TB] FAIL rd_idle_wrt: got %0d pulses expected 0", nWrt); end
   endtask

   task automatic test_back_to_back;
      bit got; int dly; logic [15:0] c; logic wn; bit st; int n; logic [15:0] y;
      logic [15:0] lo, hi, e; int nWrt, nVld;
      INT = 1'b1;
      for (int p = 0; p < 3; p++) begin
         lo = 16'($urandom); hi = 16'($urandom); e = expYaw(lo, hi);
         spiTxn(10, $urandom_range(3, 20), lo, got, dly, c, wn, st);
         nChecks++; if (got !== 1'b1 || dly != ((p == 0) ? 3 : 1)) begin nFail++; $display("[TB] FAIL b2b%0d_rdl_latency: got seen=%0b dly=%0d expected seen=1 dly=%0d", p, got, dly, (p == 0) ? 3 : 1); end
         nChecks++; if (c !== 16'hA600 || wn !== 1'b0) begin nFail++; $display("[TB] FAIL b2b%0d_rdl_cmd: got %h wrtNext=%b expected a600/0", p, c, wn); end
         if (p == 2) INT = 1'b0;
         spiTxn(10, $urandom_range(3, 20), hi, got, dly, c, wn, st);
         nChecks++; if (got !== 1'b1 || dly != 2 || c !== 16'hA700) begin nFail++; $display("[TB] FAIL b2b%0d_rdh: got seen=%0b dly=%0d cmd=%h expected 1/2/a700", p, got, dly, c); end
         nChecks++; if (yaw_rt !== lastYaw) begin nFail++; $display("[TB] FAIL b2b%0d_yaw_early: got %h expected %h", p, yaw_rt, lastYaw); end
         waitVld(10, got, n, y);
         nChecks++; if (got !== 1'b1 || n != 2 || y !== e) begin nFail++; $display("[TB] FAIL b2b%0d_yaw: got seen=%0b n=%0d yaw=%h expected 1/2/%h", p, got, n, y, e); end
         lastYaw = e;
      end
      nWrt = 0; nVld = 0;
      repeat (20) begin @(negedge clk); if (wrt === 1'b1) nWrt++; if (vld === 1'b1) nVld++; end
      nChecks++; if (nWrt != 0 || nVld != 0) begin nFail++; $display("[TB] FAIL b2b_stop: got wrt=%0d vld=%0d expected 0/0", nWrt, nVld); end
   endtask

   task automatic test_stale_done;
      bit got; int dly; logic [15:0] c; logic wn; bit st; int n; logic [15:0] y;
      logic [15:0] lo, hi, e; int nWrt, nVld;
      INT = 1'b0;
      done = 1'b0;
      repeat (2) @(negedge clk);
      done = 1'b1;
      nWrt = 0; nVld = 0;
      repeat (10) begin @(negedge clk); if (wrt === 1'b1) nWrt++; if (vld === 1'b1) nVld++; end
      nChecks++; if (nWrt != 0 || nVld != 0) begin nFail++; $display("[TB] FAIL stale_idle_rise: got wrt=%0d vld=%0d expected 0/0", nWrt, nVld); end
      INT = 1'b1;
      got = 0; n = 0;
      while (!got && n < 10) begin @(negedge clk); n++; if (wrt === 1'b1) got = 1; end
      nChecks++; if (got !== 1'b1 || cmd !== 16'hA600) begin nFail++; $display("[TB] FAIL stale_rdl: got seen=%0b cmd=%h expected 1/a600", got, cmd); end
      INT = 1'b0;
      nWrt = 0;
      repeat (12) begin @(negedge clk); if (wrt === 1'b1) nWrt++; end
      nChecks++; if (nWrt != 0) begin nFail++; $display("[TB] FAIL stale_no_advance: got %0d pulses expected 0", nWrt); end
      lo = 16'($urandom); hi = 16'($urandom); e = expYaw(lo, hi);
      done = 1'b0;
      @(negedge clk);
      rd_data = lo; done = 1'b1;
      spiTxn(10, $urandom_range(3, 20), hi, got, dly, c, wn, st);
      nChecks++; if (got !== 1'b1 || dly != 2 || c !== 16'hA700) begin nFail++; $display("[TB] FAIL stale_rdh: got seen=%0b dly=%0d cmd=%h expected 1/2/a700", got, dly, c); end
      waitVld(10, got, n, y);
      nChecks++; if (got !== 1'b1 || y !== e) begin nFail++; $display("[TB] FAIL stale_yaw: got seen=%0b yaw=%h expected 1/%h", got, y, e); end
      lastYaw = e;
   endtask

   task automatic test_reset_midread;
      bit got; int dly; logic [15:0] c; logic wn; bit st; int n; int nVld;
      INT = 1'b1;
      spiTxn(10, $urandom_range(3, 20), 16'($urandom), got, dly, c, wn, st);
      nChecks++; if (got !== 1'b1 || c !== 16'hA600) begin nFail++; $display("[TB] FAIL rstmid_rdl: got seen=%0b cmd=%h expected 1/a600", got, c); end
      INT = 1'b0;
      got = 0; n = 0;
      while (!got && n < 10) begin @(negedge clk); n++; if (wrt === 1'b1) got = 1; end
      nChecks++; if (got !== 1'b1 || cmd !== 16'hA700) begin nFail++; $display("[TB] FAIL rstmid_rdh: got seen=%0b cmd=%h expected 1/a700", got, cmd); end
      done = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      nChecks++; if (wrt !== 1'b0 || vld !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_wrt_vld: got %b/%b expected 0/0", wrt, vld); end
      nChecks++; if (yaw_rt !== 16'h0000 || cmd !== 16'h0000) begin nFail++; $display("[TB] FAIL rstmid_yaw_cmd: got %h/%h expected 0000/0000", yaw_rt, cmd); end
      nChecks++; if (init_done !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_init_done: got %b expected 0", init_done); end
      lastYaw = 16'h0000;
      rd_data = 16'($urandom); done = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      got = 0; n = 0; nVld = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (vld === 1'b1) nVld++;
         if (wrt === 1'b1) got = 1;
      end
      nChecks++; if (got !== 1'b1 || n != SETTLE_CLKS) begin nFail++; $display("[TB] FAIL rstmid_restart_delay: got seen=%0b n=%0d expected 1/%0d", got, n, SETTLE_CLKS); end
      nChecks++; if (cmd !== 16'h0D02 || nVld != 0) begin nFail++; $display("[TB] FAIL rstmid_restart_cmd: got %h vld=%0d expected 0d02/0", cmd, nVld); end
      nChecks++; if (yaw_rt !== lastYaw || init_done !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_outputs: got yaw=%h init_done=%b expected %h/0", yaw_rt, init_done, lastYaw); end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      test_reset();
      test_startup();
      test_init();
      test_single_read();
      test_back_to_back();
      test_stale_done();
      test_reset_midread();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   // Hard stop in case the sequence above never completes.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion expected end of sequence");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
